lsu_subword_ctrl: RTL and testbench

- Load/store unit between the MEM pipeline stage and the word-wide data memory.
- The data memory only supports full 32-bit word reads and writes; this block adds RV32I byte, halfword and word access.
- Loads: extract and sign/zero-extend the addressed lane.
- SB/SH: read-modify-write sequence, stalling the pipeline via a valid/ready handshake.
- Misaligned and illegal accesses are reported as errors.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_lane_align.sv | 49 ++++
 rtl/lsu_subword_ctrl.sv | 110 +++++++++++
 tb/tb_lsu_subword_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sub-word controller: funct3 encodings,
// FSM state type and access-legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    MERGE_WR = 1'b1
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = |addr_lo;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Stores only know B/H/W; loads additionally accept the unsigned variants.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3,
                                    input logic [1:0] addr_lo);
    logic f3_ok;
    if (we) f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else    f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
    return f3_ok && !is_misaligned(funct3, addr_lo);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts/extends load lanes and merges store
// lanes into an existing memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rd,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lo,
                                              input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    res = {{24{b[7]}}, b};
      F3_BU:   res = {24'd0, b};
      F3_H:    res = {{16{h[15]}}, h};
      F3_HU:   res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [31:0] wd,
                                              input logic [1:0] lo, input logic [2:0] f3);
    logic [31:0] w;
    w = old_word;
    case (f3)
      F3_B: w[{lo, 3'b000} +: 8] = wd[7:0];
      F3_H: begin
        if (lo[1]) w[31:16] = wd[15:0];
        else       w[15:0]  = wd[15:0];
      end
      default: w = wd;
    endcase
    return w;
  endfunction

  assign load_data  = load_extend(mem_rd, addr_lo, funct3);
  assign merge_data = store_merge(mem_rd, wdata, addr_lo, funct3);

endmodule

// File: rtl/lsu_subword_ctrl.sv
// Load/store unit adding RV32I byte/halfword access on top of a word-only data
// memory; sub-word stores run as a two-cycle read-modify-write.
module lsu_subword_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_re,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  lsu_state_t      state_reg;
  logic            resp_valid_reg;
  logic            resp_err_reg;
  logic [XLEN-1:0] resp_rdata_reg;
  logic [XLEN-1:0] merge_reg;
  logic [29:0]     word_addr_reg;

  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic        in_idle;
  logic        accept;
  logic        legal;
  logic        is_store_w;

  assign in_idle    = (state_reg == IDLE);
  assign accept     = in_idle && req_valid;
  assign legal      = is_legal(req_we, req_funct3, req_addr[1:0]);
  assign is_store_w = req_we && (req_funct3 == F3_W);

  lsu_lane_align u_align (
    .mem_rd     (mem_rd),
    .addr_lo    (req_addr[1:0]),
    .funct3     (req_funct3),
    .wdata      (req_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  assign req_ready = in_idle;

  // Enables are gated by rst_n so nothing reaches memory while reset is held.
  assign mem_re = rst_n && accept && legal && !is_store_w;
  assign mem_we = rst_n && ((state_reg == MERGE_WR) || (accept && legal && is_store_w));
  assign mem_a  = in_idle ? {req_addr[31:2], 2'b00} : {word_addr_reg, 2'b00};
  assign mem_wd = in_idle ? req_wdata : merge_reg;

  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
      merge_reg      <= '0;
      word_addr_reg  <= '0;
    end else begin
      resp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            if (!legal) begin
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= '0;
            end else if (!req_we) begin
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b0;
              resp_rdata_reg <= load_data;
            end else if (is_store_w) begin
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b0;
              resp_rdata_reg <= '0;
            end else begin
              // Sub-word store: hold the merged word and write it next cycle.
              merge_reg     <= merge_data;
              word_addr_reg <= req_addr[31:2];
              state_reg     <= MERGE_WR;
            end
          end
        end
        MERGE_WR: begin
          state_reg      <= IDLE;
          resp_valid_reg <= 1'b1;
          resp_err_reg   <= 1'b0;
          resp_rdata_reg <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Directed plus randomized bench for lsu_subword_ctrl with a byte-level
// reference memory model.
module tb_lsu_subword_ctrl;

  localparam logic [31:0] FILL_WORD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_subword_ctrl #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // Word-wide data memory (1 KiB window), unwritten words read as FILL_WORD.
  logic [31:0] dmem [0:255];
  bit   [255:0] written;
  assign mem_rd = written[mem_a[9:2]] ? dmem[mem_a[9:2]] : FILL_WORD;
  always @(posedge clk) begin
    if (mem_we) begin
      dmem[mem_a[9:2]]    <= mem_wd;
      written[mem_a[9:2]] <= 1'b1;
    end
  end

  // Reference: byte-addressed little-endian memory.
  logic [7:0] ref_bytes [0:1023];

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit ref_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    bit ok;
    int a;
    if (we) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    a = int'(addr[9:0]);
    return ok && ((a % size_of(f3)) == 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    longint v;
    int sz;
    int a;
    v = 0;
    sz = size_of(f3);
    a = int'(addr[9:0]);
    for (int i = 0; i < sz; i++) v = v + (longint'(ref_bytes[a + i]) << (8 * i));
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int a;
    a = int'(addr[9:0]) & ~3;
    return {ref_bytes[a + 3], ref_bytes[a + 2], ref_bytes[a + 1], ref_bytes[a]};
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int a;
    logic [31:0] d;
    a = int'(addr[9:0]);
    d = wd;
    for (int i = 0; i < size_of(f3); i++) ref_bytes[a + i] = d[8*i +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request, run to completion; returns response data and the written word.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] got_rd,
                        output logic [31:0] got_wd);
    bit legal;
    bit sub;
    logic [31:0] exp_rd;
    legal  = ref_legal(we, f3, addr);
    sub    = we && legal && (f3 != 3'd2);
    exp_rd = (!we && legal) ? ref_load(f3, addr) : 32'd0;
    got_wd = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    chk("resp_idle", {31'd0, resp_valid}, 32'd0);
    chk("mem_re", {31'd0, mem_re}, {31'd0, legal && (!we || sub)});
    chk("mem_we", {31'd0, mem_we}, {31'd0, legal && we && !sub});
    chk("mem_a", mem_a, {addr[31:2], 2'b00});
    if (legal && we && !sub) begin
      chk("sw_wd", mem_wd, wd);
      got_wd = mem_wd;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (legal && we) ref_store(f3, addr, wd);
    if (sub) begin
      @(negedge clk);
      chk("merge_ready", {31'd0, req_ready}, 32'd0);
      chk("merge_we", {31'd0, mem_we}, 32'd1);
      chk("merge_re", {31'd0, mem_re}, 32'd0);
      chk("merge_a", mem_a, {addr[31:2], 2'b00});
      chk("merge_wd", mem_wd, ref_word(addr));
      chk("merge_noresp", {31'd0, resp_valid}, 32'd0);
      got_wd = mem_wd;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_err", {31'd0, resp_err}, {31'd0, !legal});
    got_rd = resp_rdata;
    $display("req we=%0d f3=%0d addr=%h wd=%h -> rdata=%h err=%0d", we, f3, addr, wd,
             resp_rdata, resp_err);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] wdo;
    logic [31:0] exp_q [$];
    logic [31:0] b2b_addr [4];

    for (int i = 0; i < 1024; i++) ref_bytes[i] = FILL_WORD[8*(i%4) +: 8];

    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100; req_wdata = 32'd0;
    #12;
    chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b1, 3'd2, 32'h100, 32'h11223344, rd, wdo);
    do_req(1'b0, 3'd2, 32'h100, 32'd0, rd, wdo);
    chk("lw_100", rd, 32'h11223344);
    do_req(1'b1, 3'd0, 32'h102, 32'h000000AA, rd, wdo);
    chk("sb_merge", wdo, 32'h11AA3344);
    do_req(1'b0, 3'd0, 32'h102, 32'd0, rd, wdo);
    chk("lb_102", rd, 32'hFFFFFFAA);
    do_req(1'b0, 3'd4, 32'h102, 32'd0, rd, wdo);
    chk("lbu_102", rd, 32'h000000AA);
    do_req(1'b1, 3'd1, 32'h202, 32'h0000BEEF, rd, wdo);
    chk("sh_merge", wdo, 32'hBEEFBEEF);
    do_req(1'b0, 3'd5, 32'h202, 32'd0, rd, wdo);
    chk("lhu_202", rd, 32'h0000BEEF);
    do_req(1'b0, 3'd1, 32'h200, 32'd0, rd, wdo);
    chk("lh_200", rd, 32'hFFFFBEEF);

    do_req(1'b0, 3'd2, 32'h101, 32'd0, rd, wdo);
    do_req(1'b1, 3'd1, 32'h103, 32'h1234, rd, wdo);
    do_req(1'b0, 3'd3, 32'h104, 32'd0, rd, wdo);
    do_req(1'b1, 3'd4, 32'h108, 32'h55, rd, wdo);

    // Four back-to-back word loads.
    b2b_addr[0] = 32'h100; b2b_addr[1] = 32'h104; b2b_addr[2] = 32'h200; b2b_addr[3] = 32'h3FC;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = b2b_addr[i];
      exp_q.push_back(ref_load(3'd2, b2b_addr[i]));
      @(negedge clk);
      chk("b2b_ready", {31'd0, req_ready}, 32'd1);
      if (i > 0) begin
        chk("b2b_valid", {31'd0, resp_valid}, 32'd1);
        chk("b2b_rdata", resp_rdata, exp_q.pop_front());
        $display("b2b resp %0d rdata=%h", i - 1, resp_rdata);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", {31'd0, resp_valid}, 32'd1);
    chk("b2b_rdata", resp_rdata, exp_q.pop_front());
    $display("b2b resp 3 rdata=%h", resp_rdata);

    // Reset asserted in the merge cycle drops the write.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h104; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstm_ready", {31'd0, req_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_we", {31'd0, mem_we}, 32'd0);
    chk("rstm_ready_rst", {31'd0, req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstm_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstm_we_after", {31'd0, mem_we}, 32'd0);
    chk("rstm_ready_after", {31'd0, req_ready}, 32'd1);
    $display("reset during merge: ready=%0d resp_valid=%0d", req_ready, resp_valid);
    do_req(1'b0, 3'd2, 32'h104, 32'd0, rd, wdo);
    chk("rstm_unchanged", rd, FILL_WORD);

    // Randomized traffic, half of it in a small window to get store/load overlap.
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      logic [2:0]  f3;
      logic        we;
      we = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
         : (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
      if (n % 2 == 0) a = 32'h300 + 32'($urandom_range(0, 31));
      else            a = 32'($urandom_range(0, 1023));
      if (($urandom_range(0, 3) != 0) && f3[1:0] == 2'b01) a[0] = 1'b0;
      if (($urandom_range(0, 3) != 0) && f3[1:0] == 2'b10) a[1:0] = 2'b00;
      do_req(we, f3, a, $urandom, rd, wdo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
